// File: rtl/mul_pipe_rv_pkg.sv
// mul_pipe_rv_pkg: shared types for the EX-stage multiplier.
// Op encoding matches funct3[1:0] of RV32M MUL/MULH/MULHSU/MULHU.
`timescale 1ns/1ps
package mul_pipe_rv_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_e;

endpackage

// File: rtl/mul_pipe_rv_if.sv
// mul_pipe_rv_if: issue (in_*) and result (out_*) handshakes.
// master = issuing/consuming side, slave = the multiplier.
`timescale 1ns/1ps
interface mul_pipe_rv_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) ();

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [XLEN-1:0]  a;
  logic [XLEN-1:0]  b;
  logic [TAG_W-1:0] tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, op, a, b, tag,
    output out_ready,
    input  in_ready, out_valid,
    input  result, out_tag
  );

  modport slave (
    input  in_valid, op, a, b, tag,
    input  out_ready,
    output in_ready, out_valid,
    output result, out_tag
  );

endinterface

// File: rtl/mul_pipe_rv.sv
// mul_pipe_rv: pipelined RV32M multiplier, valid/ready + tag + flush.
// Define MUL_OPCOUNT_EN for the 32-bit retired-op counter.
`timescale 1ns/1ps
module mul_pipe_rv
  import mul_pipe_rv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 3,
  parameter int TAG_W  = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  mul_pipe_rv_if.slave bus,
  output logic         busy,
  output logic [31:0]  op_count
);

  localparam int H  = XLEN / 2;
  localparam int PP = 2 * H + 2;
  localparam int PW = 2 * XLEN;

  typedef struct packed {
    logic             v;
    mul_op_e          op;
    logic [TAG_W-1:0] tag;
    logic [PP-1:0]    ll;
    logic [PP-1:0]    lh;
    logic [PP-1:0]    hl;
    logic [PP-1:0]    hh;
  } s1_t;

  typedef struct packed {
    logic             v;
    mul_op_e          op;
    logic [TAG_W-1:0] tag;
    logic [PW-1:0]    p;
  } s2_t;

  s1_t s1_q, s1_d;
  s2_t s2_q, s2_d;

  logic adv;
  logic accept;
  logic out_v;

  assign adv          = !out_v | bus.out_ready;
  assign bus.in_ready = adv & !flush;
  assign accept       = bus.in_valid & bus.in_ready;

  mul_op_e op_in;
  logic    a_sgn;
  logic    b_sgn;

  assign op_in = mul_op_e'(bus.op);
  assign a_sgn = (op_in != OP_MULHU);
  assign b_sgn = (op_in == OP_MUL)
               | (op_in == OP_MULH);

  logic [XLEN:0] ax;
  logic [XLEN:0] bx;

  assign ax = {a_sgn & bus.a[XLEN-1], bus.a};
  assign bx = {b_sgn & bus.b[XLEN-1], bus.b};

  // Low halves unsigned, high halves signed, all
  // widened so each partial product is exact.
  logic signed [PP-1:0] al, ah, bl, bh;

  assign al = {{(PP-H){1'b0}}, ax[H-1:0]};
  assign bl = {{(PP-H){1'b0}}, bx[H-1:0]};
  assign ah = {{(PP-H-1){ax[XLEN]}}, ax[XLEN:H]};
  assign bh = {{(PP-H-1){bx[XLEN]}}, bx[XLEN:H]};

  always_comb begin
    s1_d     = '0;
    s1_d.v   = accept;
    s1_d.op  = op_in;
    s1_d.tag = bus.tag;
    s1_d.ll  = al * bl;
    s1_d.lh  = al * bh;
    s1_d.hl  = ah * bl;
    s1_d.hh  = ah * bh;
  end

  function automatic logic [PW-1:0] sx(
    input logic [PP-1:0] x
  );
    return {{(PW-PP){x[PP-1]}}, x};
  endfunction

  // Bits above 2*XLEN are never selected,
  // so the sum is kept modulo 2^(2*XLEN).
  always_comb begin
    s2_d     = '0;
    s2_d.v   = s1_q.v;
    s2_d.op  = s1_q.op;
    s2_d.tag = s1_q.tag;
    s2_d.p   = sx(s1_q.ll)
             + (sx(s1_q.lh) << H)
             + (sx(s1_q.hl) << H)
             + (sx(s1_q.hh) << (2 * H));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      if (adv) begin
        s1_q <= s1_d;
        s2_q <= s2_d;
      end
      if (flush) begin
        s1_q.v <= 1'b0;
        s2_q.v <= 1'b0;
      end
    end
  end

  logic [XLEN-1:0] res2;

  assign res2 = (s2_q.op == OP_MUL)
              ? s2_q.p[XLEN-1:0]
              : s2_q.p[2*XLEN-1:XLEN];

  logic             tail_v;
  logic [XLEN-1:0]  tail_r;
  logic [TAG_W-1:0] tail_t;
  logic             tail_busy;

  if (STAGES > 2) begin : g_tail
    localparam int D = STAGES - 2;

    logic [D-1:0]     v_q;
    logic [XLEN-1:0]  r_q [D];
    logic [TAG_W-1:0] t_q [D];

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= '0;
        for (int i = 0; i < D; i++) begin
          r_q[i] <= '0;
          t_q[i] <= '0;
        end
      end else begin
        if (adv) begin
          v_q[0] <= s2_q.v;
          r_q[0] <= res2;
          t_q[0] <= s2_q.tag;
          for (int i = 1; i < D; i++) begin
            v_q[i] <= v_q[i-1];
            r_q[i] <= r_q[i-1];
            t_q[i] <= t_q[i-1];
          end
        end
        if (flush) v_q <= '0;
      end
    end

    assign tail_v    = v_q[D-1];
    assign tail_r    = r_q[D-1];
    assign tail_t    = t_q[D-1];
    assign tail_busy = |v_q;
  end else begin : g_notail
    assign tail_v    = s2_q.v;
    assign tail_r    = res2;
    assign tail_t    = s2_q.tag;
    assign tail_busy = 1'b0;
  end

  assign out_v         = tail_v;
  assign bus.out_valid = out_v;
  assign bus.result    = tail_r;
  assign bus.out_tag   = tail_t;

  assign busy = s1_q.v | s2_q.v | tail_busy;

`ifdef MUL_OPCOUNT_EN
  logic        retire;
  logic [31:0] cnt_q, cnt_d;

  // A result killed by flush in its hand-off
  // cycle is not counted.
  assign retire = out_v & bus.out_ready & !flush;
  assign cnt_d  = cnt_q + 32'd1;

  always_ff @(posedge clk) begin
    if (rst)         cnt_q <= '0;
    else if (retire) cnt_q <= cnt_d;
  end

  assign op_count = cnt_q;
`else
  assign op_count = 32'h0;
`endif

endmodule

// File: tb/tb_mul_pipe_rv.sv
// tb_mul_pipe_rv: vector table + scoreboard bench for mul_pipe_rv.
// Counter checks adapt to MUL_OPCOUNT_EN.
`timescale 1ns/1ps
module tb_mul_pipe_rv;

`ifdef MUL_OPCOUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        busy;
  logic [31:0] op_count;

  mul_pipe_rv_if #(.XLEN(32), .TAG_W(5)) bus ();

  mul_pipe_rv #(
    .XLEN(32), .STAGES(3), .TAG_W(5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .bus      (bus),
    .busy     (busy),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  tag;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  exp_t        sbq [$];
  exp_t        mon_e;
  logic [31:0] drv_exp;
  int          n_chk  = 0;
  int          n_pass = 0;
  int          n_ret  = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h",
                  nm, act, exp);
  endtask

  function automatic logic [31:0] model(
    input logic [1:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [63:0] ax, bx, p;
    ax = (op == 2'b11) ? {32'h0, a}
                       : {{32{a[31]}}, a};
    bx = (op[1] == 1'b0) ? {{32{b[31]}}, b}
                         : {32'h0, b};
    p  = ax * bx;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Scoreboard: push on accept, pop on retire.
  always @(negedge clk) begin
    if (!rst && bus.out_valid &&
        bus.out_ready && !flush) begin
      n_ret++;
      if (sbq.size() == 0) begin
        n_chk++;
        $display("FAIL sb_spurious: got result %h tag %0d, want none",
                 bus.result, bus.out_tag);
      end else begin
        mon_e = sbq.pop_front();
        chk("sb_result", bus.result, mon_e.res);
        chk("sb_tag", 32'(bus.out_tag), 32'(mon_e.tag));
      end
    end
    if (rst || flush) sbq.delete();
    else if (bus.in_valid && bus.in_ready)
      sbq.push_back(exp_t'{res: drv_exp, tag: bus.tag});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [1:0] op,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [4:0] tg,
                     input logic [31:0] ex);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    bus.tag      = tg;
    drv_exp      = ex;
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    @(negedge clk);
    while ((busy || sbq.size() != 0) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 32'(busy || sbq.size() != 0), 32'd0);
  endtask

  task automatic wait_out(input string nm);
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 32'(bus.out_valid), 32'd1);
  endtask

  vec_t        tbl [12];
  logic [31:0] held;
  logic [1:0]  rop;
  logic [31:0] ra, rb;
  int          idx, r0, sent;
  bit          pend;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    tbl[1]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    tbl[2]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
    tbl[3]  = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tbl[4]  = '{2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
    tbl[5]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[6]  = '{2'b01, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF};
    tbl[7]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    tbl[8]  = '{2'b11, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001};
    tbl[9]  = '{2'b00, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780};
    tbl[10] = '{2'b11, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[11] = '{2'b01, 32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000};

    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.op        = 2'b00;
    bus.a         = '0;
    bus.b         = '0;
    bus.tag       = '0;
    drv_exp       = '0;

    // reset state
    step();
    step();
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_out_tag", 32'(bus.out_tag), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_op_count", op_count, 32'd0);
    step();
    rst = 1'b0;

    // vector table, back to back
    for (int i = 0; i < 12; i++) begin
      put(tbl[i].op, tbl[i].a, tbl[i].b,
          5'(i + 1), tbl[i].exp);
      step();
    end
    bus.in_valid = 1'b0;
    drain("tbl_drain");
    chk("tbl_retired", 32'(n_ret), 32'd12);
    chk("tbl_op_count", op_count,
        CNT_EN ? 32'd12 : 32'd0);

    // exact 3-cycle latency
    step();
    put(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        5'd7, 32'hFFFF_FFFE);
    @(negedge clk);
    chk("lat_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("lat_c1_valid", 32'(bus.out_valid), 32'd0);
    step();
    @(negedge clk);
    chk("lat_c2_valid", 32'(bus.out_valid), 32'd0);
    step();
    @(negedge clk);
    chk("lat_c3_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_c3_result", bus.result, 32'hFFFF_FFFE);
    chk("lat_c3_tag", 32'(bus.out_tag), 32'd7);
    drain("lat_drain");

    // backpressure: 4 ops, out_ready low cycles 4-6
    idx = 0;
    r0  = n_ret;
    held = '0;
    for (int c = 1; c <= 14; c++) begin
      step();
      bus.out_ready = !(c >= 4 && c <= 6);
      if (idx < 4)
        put(2'b00, 32'(idx * 3 + 1), 32'(idx + 5),
            5'(idx + 1),
            model(2'b00, 32'(idx * 3 + 1),
                  32'(idx + 5)));
      else
        bus.in_valid = 1'b0;
      @(negedge clk);
      if (c >= 4 && c <= 6) begin
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_out_tag", 32'(bus.out_tag), 32'd1);
        if (c == 4) held = bus.result;
        else chk("bp_result_held", bus.result, held);
      end
      if (bus.in_valid && bus.in_ready) idx++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drain("bp_drain");
    chk("bp_accepted", 32'(idx), 32'd4);
    chk("bp_retired", 32'(n_ret - r0), 32'd4);

    // flush with two ops in flight
    step();
    put(2'b00, 32'd3, 32'd4, 5'd9, 32'd12);
    step();
    put(2'b00, 32'd5, 32'd6, 5'd10, 32'd30);
    step();
    put(2'b00, 32'd7, 32'd8, 5'd11, 32'd56);
    flush = 1'b1;
    @(negedge clk);
    chk("fl_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    r0 = n_ret;
    @(negedge clk);
    chk("fl_busy", 32'(busy), 32'd0);
    chk("fl_out_valid", 32'(bus.out_valid), 32'd0);
    repeat (5) begin
      step();
      @(negedge clk);
      chk("fl_no_out", 32'(bus.out_valid), 32'd0);
    end
    chk("fl_retired", 32'(n_ret - r0), 32'd0);

    // 5 retires, then one op flushed while out_ready=1
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      put(tbl[i].op, tbl[i].a, tbl[i].b,
          5'(i + 20), tbl[i].exp);
      step();
    end
    bus.in_valid = 1'b0;
    drain("cnt_drain");
    step();
    bus.out_ready = 1'b0;
    put(2'b00, 32'd9, 32'd9, 5'd31, 32'd81);
    step();
    bus.in_valid = 1'b0;
    wait_out("cnt_wait_out");
    step();
    flush = 1'b1;
    bus.out_ready = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("cnt_fl_valid", 32'(bus.out_valid), 32'd0);
    chk("cnt_fl_busy", 32'(busy), 32'd0);
    chk("cnt_five", op_count,
        CNT_EN ? 32'd5 : 32'd0);

`ifdef MUL_OPCOUNT_EN
    // wrap 0xFFFFFFFF -> 0
    step();
    force dut.cnt_q = 32'hFFFF_FFFF;
    step();
    release dut.cnt_q;
    @(negedge clk);
    chk("cnt_preload", op_count, 32'hFFFF_FFFF);
    step();
    put(2'b00, 32'd2, 32'd2, 5'd1, 32'd4);
    step();
    bus.in_valid = 1'b0;
    drain("wrap_drain");
    chk("cnt_wrap", op_count, 32'd0);
`endif

    // reset mid-operation
    step();
    put(2'b01, 32'h8000_0000, 32'h8000_0000,
        5'd3, 32'h4000_0000);
    step();
    put(2'b00, 32'd11, 32'd13, 5'd4, 32'd143);
    step();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    r0 = n_ret;
    @(negedge clk);
    chk("rmid_busy", 32'(busy), 32'd0);
    chk("rmid_result", bus.result, 32'd0);
    chk("rmid_tag", 32'(bus.out_tag), 32'd0);
    chk("rmid_op_count", op_count, 32'd0);
    repeat (4) begin
      step();
      @(negedge clk);
      chk("rmid_no_out", 32'(bus.out_valid), 32'd0);
    end
    chk("rmid_retired", 32'(n_ret - r0), 32'd0);

    // random stream with random backpressure
    sent = 0;
    pend = 1'b0;
    r0   = n_ret;
    for (int c = 0; c < 600 && sent < 40; c++) begin
      step();
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (!pend) begin
        if ($urandom_range(0, 3) != 0) begin
          rop = 2'($urandom_range(0, 3));
          ra  = ($urandom_range(0, 4) == 0)
              ? 32'h8000_0000 : 32'($urandom);
          rb  = ($urandom_range(0, 4) == 0)
              ? 32'hFFFF_FFFF : 32'($urandom);
          put(rop, ra, rb, 5'(sent),
              model(rop, ra, rb));
          pend = 1'b1;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        pend = 1'b0;
        sent++;
      end
    end
    step();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drain("rnd_drain");
    chk("rnd_sent", 32'(sent), 32'd40);
    chk("rnd_retired", 32'(n_ret - r0), 32'd40);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
